// File: rtl/signed_prod_accum.sv
// signed_prod_accum: frame-based saturating accumulator for the signed
// multiplier product stream. din0 is summed over FRAME_LEN valid samples,
// and din1 is compared against din0 on every valid sample as a cross-check.
module signed_prod_accum #(
   parameter int DIN_W     = 16,
   parameter int ACC_W     = 20,
   parameter int FRAME_LEN = 8
) (
   input  logic                    tb_clk,
   input  logic                    tb_rst_n,
   input  logic signed [DIN_W-1:0] din0,
   input  logic signed [DIN_W-1:0] din1,
   input  logic                    din_vld,
   input  logic                    clr,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    acc_vld,
   output logic                    sat_flag,
   output logic                    mismatch,
   output logic [7:0]              err_cnt,
   output logic [7:0]              frame_cnt
);

   // Frame state machine: IDLE holds count 0 / accumulator 0, ACCUM is mid-frame
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   localparam logic [7:0]       LAST_CNT = 8'(FRAME_LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

   logic [0:0]              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    sat_q, sat_d;
   logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
   logic                    acc_vld_q, acc_vld_d;
   logic                    sat_flag_q, sat_flag_d;
   logic                    mismatch_q, mismatch_d;
   logic [7:0]              err_cnt_q, err_cnt_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;

   logic [ACC_W:0]          sum;
   logic                    ovf;
   logic [ACC_W-1:0]        clamped;
   logic                    lastSample;

   // One guard bit above the accumulator: overflow shows as the top two bits disagreeing
   always_comb begin
      sum        = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-DIN_W){din0[DIN_W-1]}}, din0};
      ovf        = sum[ACC_W] ^ sum[ACC_W-1];
      clamped    = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      lastSample = (state_q == ACCUM) && (cnt_q == LAST_CNT);
   end

   // Next-state logic: clr wins over a same-cycle sample, which is dropped
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      sat_d       = sat_q;
      acc_out_d   = acc_out_q;
      acc_vld_d   = 1'b0;
      sat_flag_d  = sat_flag_q;
      mismatch_d  = mismatch_q;
      err_cnt_d   = err_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (clr) begin
         state_d    = IDLE;
         cnt_d      = '0;
         acc_d      = '0;
         sat_d      = 1'b0;
         mismatch_d = 1'b0;
         err_cnt_d  = '0;
      end else if (din_vld) begin
         if (din0 != din1) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
         end
         if (lastSample) begin
            acc_out_d   = clamped;
            sat_flag_d  = sat_q | ovf;
            acc_vld_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            sat_d       = 1'b0;
         end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + 8'd1;
            acc_d   = clamped;
            sat_d   = sat_q | ovf;
         end
      end
   end

   // State registers; a mid-frame reset simply discards the partial frame
   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         acc_out_q   <= '0;
         acc_vld_q   <= 1'b0;
         sat_flag_q  <= 1'b0;
         mismatch_q  <= 1'b0;
         err_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         acc_out_q   <= acc_out_d;
         acc_vld_q   <= acc_vld_d;
         sat_flag_q  <= sat_flag_d;
         mismatch_q  <= mismatch_d;
         err_cnt_q   <= err_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign acc_vld   = acc_vld_q;
   assign sat_flag  = sat_flag_q;
   assign mismatch  = mismatch_q;
   assign err_cnt   = err_cnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_signed_prod_accum.sv
// Testbench for signed_prod_accum: one 8-sample-frame instance and one
// 40-sample-frame instance share data, clear and reset; each has its own valid.
module tb_signed_prod_accum;

   logic              tb_clk = 1'b0;
   logic              tb_rst_n = 1'b0;
   logic signed [15:0] din0 = '0;
   logic signed [15:0] din1 = '0;
   logic              vld8 = 1'b0;
   logic              vld40 = 1'b0;
   logic              clr = 1'b0;

   logic signed [19:0] acc8, acc40;
   logic              accVld8, accVld40, sat8, sat40, mis8, mis40;
   logic [7:0]        err8, err40, frm8, frm40;

   int assertCount = 0;
   int failCount = 0;
   int pulse8 = 0;
   int pulse40 = 0;
   int base;

   signed_prod_accum #(.DIN_W(16), .ACC_W(20), .FRAME_LEN(8)) dut8 (
      .tb_clk(tb_clk), .tb_rst_n(tb_rst_n), .din0(din0), .din1(din1), .din_vld(vld8), .clr(clr),
      .acc_out(acc8), .acc_vld(accVld8), .sat_flag(sat8), .mismatch(mis8), .err_cnt(err8), .frame_cnt(frm8)
   );

   signed_prod_accum #(.DIN_W(16), .ACC_W(20), .FRAME_LEN(40)) dut40 (
      .tb_clk(tb_clk), .tb_rst_n(tb_rst_n), .din0(din0), .din1(din1), .din_vld(vld40), .clr(clr),
      .acc_out(acc40), .acc_vld(accVld40), .sat_flag(sat40), .mismatch(mis40), .err_cnt(err40), .frame_cnt(frm40)
   );

   // 100 MHz clock
   always #5 tb_clk = ~tb_clk;

   // Count acc_vld pulses, sampled just after each rising edge
   always @(posedge tb_clk) begin
      #1;
      if (accVld8 === 1'b1) pulse8++;
      if (accVld40 === 1'b1) pulse40++;
   end

   task automatic applyStimulus(input logic signed [15:0] d0, input logic signed [15:0] d1,
                                input logic v8, input logic v40, input logic c);
      @(negedge tb_clk);
      din0 = d0; din1 = d1; vld8 = v8; vld40 = v40; clr = c;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      tb_rst_n = 1'b0;
      repeat (2) @(negedge tb_clk);
      assertCount++; if (acc8 !== 20'sd0)   begin failCount++; $display("[TB] FAIL reset_acc8: got %0d expected 0", acc8); end
      assertCount++; if (accVld8 !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_vld8: got %0b expected 0", accVld8); end
      assertCount++; if ({sat8, mis8} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags8: got %b expected 00", {sat8, mis8}); end
      assertCount++; if ({err8, frm8} !== 16'h0) begin failCount++; $display("[TB] FAIL reset_cnt8: got %h expected 0000", {err8, frm8}); end
      assertCount++; if ({acc40, accVld40, sat40, mis40, err40, frm40} !== 39'h0)
         begin failCount++; $display("[TB] FAIL reset_dut40: got %h expected 0", {acc40, accVld40, sat40, mis40, err40, frm40}); end
      tb_rst_n = 1'b1;
   endtask

   task automatic test_basic_frame();
      base = pulse8;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'sd100, 16'sd100, 1'b1, 1'b0, 1'b0);
         if (i == 7) begin
            assertCount++; if (accVld8 !== 1'b0) begin failCount++; $display("[TB] FAIL basic_early_vld: got %0b expected 0", accVld8); end
         end
      end
      idle(1);
      assertCount++; if (accVld8 !== 1'b1)  begin failCount++; $display("[TB] FAIL basic_vld: got %0b expected 1", accVld8); end
      assertCount++; if (acc8 !== 20'sd800) begin failCount++; $display("[TB] FAIL basic_acc: got %0d expected 800", acc8); end
      assertCount++; if (sat8 !== 1'b0)     begin failCount++; $display("[TB] FAIL basic_sat: got %0b expected 0", sat8); end
      assertCount++; if (frm8 !== 8'd1)     begin failCount++; $display("[TB] FAIL basic_frame_cnt: got %0d expected 1", frm8); end
      assertCount++; if (err8 !== 8'd0)     begin failCount++; $display("[TB] FAIL basic_err: got %0d expected 0", err8); end
      idle(1);
      assertCount++; if (accVld8 !== 1'b0)  begin failCount++; $display("[TB] FAIL basic_vld_width: got %0b expected 0", accVld8); end
      assertCount++; if (acc8 !== 20'sd800) begin failCount++; $display("[TB] FAIL basic_acc_hold: got %0d expected 800", acc8); end
      idle(1);
      assertCount++; if (pulse8 - base !== 1) begin failCount++; $display("[TB] FAIL basic_pulses: got %0d expected 1", pulse8 - base); end
   endtask

   task automatic test_back_to_back();
      logic signed [15:0] v;
      base = pulse8;
      for (int i = 0; i < 8; i++) begin
         v = (i % 2 == 0) ? -16'sd16384 : 16'sd16384;
         applyStimulus(v, v, 1'b1, 1'b0, 1'b0);
         if (i < 7) idle(2);
      end
      applyStimulus(-16'sd3, -16'sd3, 1'b1, 1'b0, 1'b0);
      assertCount++; if (accVld8 !== 1'b1) begin failCount++; $display("[TB] FAIL gaps_vld: got %0b expected 1", accVld8); end
      assertCount++; if (acc8 !== 20'sd0)  begin failCount++; $display("[TB] FAIL gaps_acc: got %0d expected 0", acc8); end
      assertCount++; if (frm8 !== 8'd2)    begin failCount++; $display("[TB] FAIL gaps_frame_cnt: got %0d expected 2", frm8); end
      for (int i = 0; i < 7; i++) applyStimulus(-16'sd3, -16'sd3, 1'b1, 1'b0, 1'b0);
      idle(1);
      assertCount++; if (accVld8 !== 1'b1)  begin failCount++; $display("[TB] FAIL b2b_vld: got %0b expected 1", accVld8); end
      assertCount++; if (acc8 !== -20'sd24) begin failCount++; $display("[TB] FAIL b2b_acc: got %0d expected -24", acc8); end
      assertCount++; if (frm8 !== 8'd3)     begin failCount++; $display("[TB] FAIL b2b_frame_cnt: got %0d expected 3", frm8); end
      idle(2);
      assertCount++; if (pulse8 - base !== 2) begin failCount++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulse8 - base); end
   endtask

   task automatic test_saturation();
      base = pulse40;
      for (int i = 0; i < 40; i++) applyStimulus(16'sd16384, 16'sd16384, 1'b0, 1'b1, 1'b0);
      idle(1);
      assertCount++; if (accVld40 !== 1'b1)     begin failCount++; $display("[TB] FAIL satpos_vld: got %0b expected 1", accVld40); end
      assertCount++; if (acc40 !== 20'sh7FFFF)  begin failCount++; $display("[TB] FAIL satpos_acc: got %0d expected 524287", acc40); end
      assertCount++; if (sat40 !== 1'b1)        begin failCount++; $display("[TB] FAIL satpos_flag: got %0b expected 1", sat40); end
      for (int i = 0; i < 40; i++) applyStimulus(-16'sd16256, -16'sd16256, 1'b0, 1'b1, 1'b0);
      idle(1);
      assertCount++; if (acc40 !== 20'sh80000)  begin failCount++; $display("[TB] FAIL satneg_acc: got %0d expected -524288", acc40); end
      assertCount++; if (sat40 !== 1'b1)        begin failCount++; $display("[TB] FAIL satneg_flag: got %0b expected 1", sat40); end
      for (int i = 0; i < 40; i++) begin
         applyStimulus(16'sd1, 16'sd1, 1'b0, 1'b1, 1'b0);
         if (i == 20) begin
            assertCount++; if (sat40 !== 1'b1) begin failCount++; $display("[TB] FAIL sat_hold: got %0b expected 1", sat40); end
         end
      end
      idle(1);
      assertCount++; if (acc40 !== 20'sd40) begin failCount++; $display("[TB] FAIL satclr_acc: got %0d expected 40", acc40); end
      assertCount++; if (sat40 !== 1'b0)    begin failCount++; $display("[TB] FAIL satclr_flag: got %0b expected 0", sat40); end
      assertCount++; if (frm40 !== 8'd3)    begin failCount++; $display("[TB] FAIL sat_frame_cnt: got %0d expected 3", frm40); end
      idle(2);
      assertCount++; if (pulse40 - base !== 3) begin failCount++; $display("[TB] FAIL sat_pulses: got %0d expected 3", pulse40 - base); end
   endtask

   task automatic test_mismatch();
      for (int i = 1; i <= 8; i++)
         applyStimulus(16'sd5, (i == 2 || i == 4 || i == 7) ? 16'sd6 : 16'sd5, 1'b1, 1'b0, 1'b0);
      idle(1);
      assertCount++; if (acc8 !== 20'sd40) begin failCount++; $display("[TB] FAIL mis_acc: got %0d expected 40", acc8); end
      assertCount++; if (mis8 !== 1'b1)    begin failCount++; $display("[TB] FAIL mis_flag: got %0b expected 1", mis8); end
      assertCount++; if (err8 !== 8'd3)    begin failCount++; $display("[TB] FAIL mis_err3: got %0d expected 3", err8); end
      for (int i = 0; i < 252; i++) applyStimulus(16'sd1, 16'sd2, 1'b1, 1'b0, 1'b0);
      assertCount++; if (err8 !== 8'd254)  begin failCount++; $display("[TB] FAIL mis_err254: got %0d expected 254", err8); end
      applyStimulus(16'sd1, 16'sd2, 1'b1, 1'b0, 1'b0);
      assertCount++; if (err8 !== 8'd255)  begin failCount++; $display("[TB] FAIL mis_err255: got %0d expected 255", err8); end
      for (int i = 0; i < 47; i++) applyStimulus(16'sd1, 16'sd2, 1'b1, 1'b0, 1'b0);
      idle(1);
      assertCount++; if (err8 !== 8'd255)  begin failCount++; $display("[TB] FAIL mis_err_sat: got %0d expected 255", err8); end
      assertCount++; if (mis40 !== 1'b0)   begin failCount++; $display("[TB] FAIL mis_other_inst: got %0b expected 0", mis40); end
   endtask

   task automatic test_clear();
      @(negedge tb_clk);
      tb_rst_n = 1'b0; vld8 = 1'b0; vld40 = 1'b0; clr = 1'b0;
      @(negedge tb_clk);
      tb_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(16'sd10, 16'sd10, 1'b1, 1'b0, 1'b0);
      idle(2);
      assertCount++; if (acc8 !== 20'sd80) begin failCount++; $display("[TB] FAIL clr_setup_acc: got %0d expected 80", acc8); end
      base = pulse8;
      applyStimulus(16'sd50, 16'sd50, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'sd50, 16'sd51, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'sd50, 16'sd50, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'sd50, 16'sd50, 1'b1, 1'b0, 1'b1);
      assertCount++; if ({mis8, err8} !== 9'h101) begin failCount++; $display("[TB] FAIL clr_pre_err: got %h expected 101", {mis8, err8}); end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'sd1, 16'sd1, 1'b1, 1'b0, 1'b0);
         if (i == 0) begin
            assertCount++; if ({mis8, err8} !== 9'h000) begin failCount++; $display("[TB] FAIL clr_err_zero: got %h expected 000", {mis8, err8}); end
         end
         if (i == 7) begin
            assertCount++; if (accVld8 !== 1'b0) begin failCount++; $display("[TB] FAIL clr_early_vld: got %0b expected 0", accVld8); end
            assertCount++; if (acc8 !== 20'sd80) begin failCount++; $display("[TB] FAIL clr_acc_retain: got %0d expected 80", acc8); end
            assertCount++; if (frm8 !== 8'd1)    begin failCount++; $display("[TB] FAIL clr_frame_retain: got %0d expected 1", frm8); end
         end
      end
      idle(1);
      assertCount++; if (accVld8 !== 1'b1) begin failCount++; $display("[TB] FAIL clr_vld: got %0b expected 1", accVld8); end
      assertCount++; if (acc8 !== 20'sd8)  begin failCount++; $display("[TB] FAIL clr_acc: got %0d expected 8", acc8); end
      assertCount++; if (frm8 !== 8'd2)    begin failCount++; $display("[TB] FAIL clr_frame_cnt: got %0d expected 2", frm8); end
      idle(2);
      assertCount++; if (pulse8 - base !== 1) begin failCount++; $display("[TB] FAIL clr_pulses: got %0d expected 1", pulse8 - base); end
      applyStimulus(16'sd5, 16'sd9, 1'b1, 1'b0, 1'b0);
      idle(1);
      assertCount++; if ({mis8, err8} !== 9'h101) begin failCount++; $display("[TB] FAIL clr_only_pre: got %h expected 101", {mis8, err8}); end
      applyStimulus(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b1);
      idle(1);
      assertCount++; if ({mis8, err8} !== 9'h000) begin failCount++; $display("[TB] FAIL clr_only_err: got %h expected 000", {mis8, err8}); end
      assertCount++; if (acc8 !== 20'sd8 || frm8 !== 8'd2)
         begin failCount++; $display("[TB] FAIL clr_only_keep: got acc %0d frames %0d expected 8 and 2", acc8, frm8); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) applyStimulus(16'sd7, 16'sd7, 1'b1, 1'b0, 1'b0);
      @(posedge tb_clk);
      #2;
      tb_rst_n = 1'b0; vld8 = 1'b0;
      #1;
      assertCount++; if (acc8 !== 20'sd0) begin failCount++; $display("[TB] FAIL arst_acc: got %0d expected 0", acc8); end
      assertCount++; if ({accVld8, sat8, mis8, err8, frm8} !== 19'h0)
         begin failCount++; $display("[TB] FAIL arst_outputs: got %h expected 0", {accVld8, sat8, mis8, err8, frm8}); end
      @(negedge tb_clk);
      tb_rst_n = 1'b1;
      base = pulse8;
      for (int i = 0; i < 8; i++) applyStimulus(16'sd2, 16'sd2, 1'b1, 1'b0, 1'b0);
      idle(1);
      assertCount++; if (accVld8 !== 1'b1) begin failCount++; $display("[TB] FAIL arst_vld: got %0b expected 1", accVld8); end
      assertCount++; if (acc8 !== 20'sd16) begin failCount++; $display("[TB] FAIL arst_acc16: got %0d expected 16", acc8); end
      assertCount++; if (frm8 !== 8'd1)    begin failCount++; $display("[TB] FAIL arst_frame_cnt: got %0d expected 1", frm8); end
      idle(2);
      assertCount++; if (pulse8 - base !== 1) begin failCount++; $display("[TB] FAIL arst_pulses: got %0d expected 1", pulse8 - base); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_saturation();
      test_mismatch();
      test_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
